// File: rtl/axi_fifo_wr_arbiter.sv
// Round-robin write-port scheduler that hands the shared async FIFO to one requester per burst.
// Optional macro AXI_FIFO_ARB_HDR_EN inserts a {cur_id, len} header word ahead of each burst.
module axi_fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                            write_clk,
  input  logic                            write_rst,
  input  logic                            clear,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              grant,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]      cur_id,
  output logic                            busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd2;
`ifdef AXI_FIFO_ARB_HDR_EN
  localparam logic [1:0] HDR   = 2'd1;
`endif

  logic [1:0]            state_r;
  logic [NUM_REQ-1:0]    grant_r;
  logic [ID_W-1:0]       cur_id_r;
  logic [ID_W-1:0]       rr_ptr_r;
  logic [LEN_WIDTH-1:0]  cnt_r;

  logic [ID_W:0]         sum_s;
  logic [ID_W-1:0]       idx_s;
  logic [ID_W-1:0]       winner_s;
  logic                  found_s;
  logic [LEN_WIDTH-1:0]  win_len_s;
  logic                  cur_valid_s;
  logic [DATA_WIDTH-1:0] cur_data_s;
  logic [ID_W-1:0]       rr_next_s;
  logic                  beat_s;
  logic                  hdr_wr_s;

  // Round-robin search from the rr pointer, wrapping modulo NUM_REQ; first hit wins.
  always_comb begin
    winner_s = rr_ptr_r;
    found_s  = 1'b0;
    sum_s    = {(ID_W+1){1'b0}};
    idx_s    = {ID_W{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      if (sum_s >= (ID_W+1)'(NUM_REQ)) begin
        idx_s = ID_W'(sum_s - (ID_W+1)'(NUM_REQ));
      end else begin
        idx_s = ID_W'(sum_s);
      end
      if (!found_s && req[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Per-requester slice selection for the winner's length and the owner's data/valid.
  always_comb begin
    win_len_s   = {LEN_WIDTH{1'b0}};
    cur_valid_s = 1'b0;
    cur_data_s  = {DATA_WIDTH{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner_s == ID_W'(k)) begin
        win_len_s = req_len[k*LEN_WIDTH +: LEN_WIDTH];
      end else begin
        win_len_s = win_len_s;
      end
      if (cur_id_r == ID_W'(k)) begin
        cur_valid_s = req_valid[k];
        cur_data_s  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        cur_valid_s = cur_valid_s;
      end
    end
  end

  assign rr_next_s = (cur_id_r == ID_W'(NUM_REQ-1)) ? {ID_W{1'b0}} : cur_id_r + ID_W'(1);
  assign beat_s    = (state_r == BURST) & cur_valid_s & ~fifo_full & ~clear;

`ifdef AXI_FIFO_ARB_HDR_EN
  logic [DATA_WIDTH-1:0] hdr_word_s;

  assign hdr_wr_s = (state_r == HDR) & ~fifo_full & ~clear;

  // Header layout: latched length in the low bits, owner id just above it.
  always_comb begin
    hdr_word_s                         = {DATA_WIDTH{1'b0}};
    hdr_word_s[LEN_WIDTH-1:0]          = cnt_r;
    hdr_word_s[LEN_WIDTH +: ID_W]      = cur_id_r;
  end

  assign fifo_wr_data = (state_r == HDR) ? hdr_word_s : cur_data_s;
`else
  assign hdr_wr_s     = 1'b0;
  assign fifo_wr_data = cur_data_s;
`endif

  assign fifo_wr_en = beat_s | hdr_wr_s;
  assign grant      = grant_r;
  assign cur_id     = cur_id_r;
  assign busy       = (state_r != IDLE);

  // Only the owner sees ready, and only while a data beat could actually be written.
  always_comb begin
    req_ready = {NUM_REQ{1'b0}};
    if ((state_r == BURST) && !clear && !fifo_full) begin
      req_ready = grant_r;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
  end

  // Burst FSM: clear abandons any partial burst and restarts arbitration from requester 0.
  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      state_r  <= IDLE;
      grant_r  <= {NUM_REQ{1'b0}};
      cur_id_r <= {ID_W{1'b0}};
      rr_ptr_r <= {ID_W{1'b0}};
      cnt_r    <= {LEN_WIDTH{1'b0}};
    end else if (clear) begin
      state_r  <= IDLE;
      grant_r  <= {NUM_REQ{1'b0}};
      rr_ptr_r <= {ID_W{1'b0}};
      cnt_r    <= {LEN_WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r  <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
            cur_id_r <= winner_s;
            cnt_r    <= win_len_s;
`ifdef AXI_FIFO_ARB_HDR_EN
            state_r  <= HDR;
`else
            state_r  <= BURST;
`endif
          end
        end
`ifdef AXI_FIFO_ARB_HDR_EN
        HDR: begin
          if (hdr_wr_s) begin
            state_r <= BURST;
          end
        end
`endif
        BURST: begin
          if (beat_s) begin
            if (cnt_r == {LEN_WIDTH{1'b0}}) begin
              grant_r  <= {NUM_REQ{1'b0}};
              rr_ptr_r <= rr_next_s;
              state_r  <= IDLE;
            end else begin
              cnt_r <= cnt_r - LEN_WIDTH'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {NUM_REQ{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_fifo_wr_arbiter.sv
// Self-checking bench for axi_fifo_wr_arbiter: transaction-level reference model plus directed and random scenarios.
// Honours AXI_FIFO_ARB_HDR_EN when the bundle is built with it.
module tb_axi_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 8;
`ifdef AXI_FIFO_ARB_HDR_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic            write_clk = 1'b0;
  logic            write_rst;
  logic            clear;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    grant;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wr_data;
  logic [1:0]      cur_id;
  logic            busy;

  axi_fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .write_clk(write_clk), .write_rst(write_rst), .clear(clear),
    .req(req), .req_len(req_len), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .grant(grant), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .cur_id(cur_id), .busy(busy)
  );

  always #5 write_clk = ~write_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = idle), beats still owed, next search start, header pending.
  int m_owner, m_left, m_rr, m_cur;
  bit m_hdr;
  int dut_wr, bad_full;
  logic [DW-1:0] wr_log[$];

  function automatic void model_reset();
    m_owner = -1; m_left = 0; m_rr = 0; m_cur = 0; m_hdr = 1'b0;
  endfunction

  function automatic void model_update();
    bit found;
    int i;
    found = 1'b0;
    if (clear) begin
      m_owner = -1; m_rr = 0; m_hdr = 1'b0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        i = (m_rr + k) % N;
        if (!found && req[i]) begin
          found = 1'b1; m_owner = i; m_cur = i;
          m_left = int'(req_len[i*LW +: LW]) + 1; m_hdr = (H == 1);
        end
      end
    end else if (m_hdr) begin
      if (!fifo_full) m_hdr = 1'b0;
    end else if (!fifo_full && req_valid[m_owner]) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_rr = (m_owner + 1) % N; m_owner = -1;
      end
    end
  endfunction

  function automatic logic [43:0] exp_vec();
    logic [3:0] g = 4'h0, r = 4'h0;
    logic w = 1'b0;
    logic [31:0] d = 32'h0;
    if (m_owner >= 0) begin
      g = 4'b0001 << m_owner;
      w = !clear && !fifo_full && (m_hdr || req_valid[m_owner]);
      if (!m_hdr && !clear && !fifo_full) r = g;
      if (w) d = m_hdr ? (32'(m_left - 1) | (32'(m_owner) << 8)) : req_data[m_owner*DW +: DW];
    end
    return {g, 2'(m_cur), (m_owner >= 0), w, r, d};
  endfunction

  function automatic logic [43:0] obs_vec();
    return {grant, cur_id, busy, fifo_wr_en, req_ready, (fifo_wr_en ? fifo_wr_data : 32'h0)};
  endfunction

  task automatic tick();
    if (fifo_wr_en) begin
      dut_wr++;
      wr_log.push_back(fifo_wr_data);
      if (fifo_full) bad_full++;
    end
    @(posedge write_clk);
    model_update();
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*LW +: LW] = LW'(v);
  endtask

  task automatic rand_data();
    req_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic test_reset();
    write_rst = 1'b0; clear = 1'b0; req = 4'h0; req_len = 32'h0; req_data = 128'h0;
    req_valid = 4'h0; fifo_full = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== 44'h0) begin
      errors++; $display("FAIL reset_state: got %h expected %h", obs_vec(), 44'h0);
    end
    tick(); tick();
    write_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_idle c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_single_burst();
    dut_wr = 0; wr_log.delete();
    req = 4'b0100; set_len(2, 3); req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      if (c >= 2) req = 4'h0;
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL single c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      if (c == 1) begin
        checks++;
        if (grant !== 4'b0100) begin
          errors++; $display("FAIL single_grant_latency: got %b expected %b", grant, 4'b0100);
        end
      end
      tick();
    end
    checks++;
    if (dut_wr != 4 + H) begin
      errors++; $display("FAIL single_beats: got %0d expected %0d", dut_wr, 4 + H);
    end
    // rr pointer must now be 3: with 0,1,3 requesting, 3 wins.
    req = 4'b1011; set_len(3, 0);
    #1; tick();
    checks++;
    if (cur_id !== 2'd3 || grant !== 4'b1000) begin
      errors++; $display("FAIL single_rr_ptr: got id %0d grant %b expected id 3 grant 1000", cur_id, grant);
    end
    req = 4'h0;
    for (int c = 0; c < 5; c++) begin
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL single_drain c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    int ids[$];
    int want[5];
    logic prev_busy;
    want = '{0, 1, 2, 3, 0};
    clear = 1'b1; #1; tick(); clear = 1'b0;
    req = 4'hF; req_len = 32'h0; req_valid = 4'hF; prev_busy = 1'b0;
    for (int c = 0; c < 5 * (2 + H); c++) begin
      rand_data();
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rr c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      if (busy && !prev_busy) ids.push_back(int'(cur_id));
      prev_busy = busy;
      tick();
    end
    req = 4'h0;
    for (int c = 0; c < 3; c++) begin
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rr_drain c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (ids.size() != 5) begin
      errors++; $display("FAIL rr_count: got %0d expected 5", ids.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (ids[k] != want[k]) begin
          errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, ids[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_full_stall();
    dut_wr = 0; bad_full = 0;
    req = 4'b0010; set_len(1, 5); req_valid = 4'hF;
    for (int c = 0; c < 16; c++) begin
      rand_data();
      if (c >= 2) req = 4'h0;
      fifo_full = (c >= 4 && c <= 6);
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    fifo_full = 1'b0;
    checks++;
    if (dut_wr != 6 + H) begin
      errors++; $display("FAIL stall_beats: got %0d expected %0d", dut_wr, 6 + H);
    end
    checks++;
    if (bad_full != 0) begin
      errors++; $display("FAIL stall_wr_while_full: got %0d expected 0", bad_full);
    end
  endtask

  task automatic test_clear();
    req = 4'b0100; set_len(2, 7); set_len(0, 1); req_valid = 4'hF;
    for (int c = 0; c <= 3 + H; c++) begin
      rand_data();
      clear = (c == 3 + H);
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL clear c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      if (clear) begin
        checks++;
        if (fifo_wr_en !== 1'b0 || req_ready !== 4'h0) begin
          errors++; $display("FAIL clear_suppress: got wr %b ready %b expected 0 0000", fifo_wr_en, req_ready);
        end
      end
      tick();
    end
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || grant !== 4'h0) begin
      errors++; $display("FAIL clear_idle: got busy %b grant %b expected 0 0000", busy, grant);
    end
    req = 4'b0101;
    #1; tick();
    checks++;
    if (grant !== 4'b0001) begin
      errors++; $display("FAIL clear_rr_reset: got grant %b expected 0001", grant);
    end
    req = 4'h0;
    for (int c = 0; c < 8; c++) begin
      rand_data();
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL clear_drain c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0001; set_len(0, 7); set_len(1, 1); req_valid = 4'hF;
    for (int c = 0; c < 4; c++) begin
      rand_data(); #1; tick();
    end
    req = 4'h0;
    write_rst = 1'b0;
    #1; checks++;
    if ({grant, cur_id, busy, fifo_wr_en, req_ready} !== 12'h0) begin
      errors++; $display("FAIL reset_async: got %h expected 000", {grant, cur_id, busy, fifo_wr_en, req_ready});
    end
    model_reset();
    tick(); tick();
    write_rst = 1'b1;
    for (int c = 0; c < 9; c++) begin
      rand_data();
      req = (c == 3) ? 4'b0010 : 4'h0;
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL reset_after c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    bad_full = 0;
    for (int c = 0; c < 400; c++) begin
      req = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) set_len(i, $urandom_range(0, 3));
      rand_data();
      req_valid = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      fifo_full = ($urandom_range(0, 4) == 0);
      clear = ($urandom_range(0, 29) == 0);
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    req = 4'h0; clear = 1'b0; fifo_full = 1'b0; req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      rand_data();
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random_drain c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (bad_full != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL random_end: got full-writes %0d busy %b expected 0 0", bad_full, busy);
    end
  endtask

`ifdef AXI_FIFO_ARB_HDR_EN
  task automatic test_header();
    logic [31:0] hdr_exp;
    hdr_exp = 32'h0000_0302;
    wr_log.delete();
    req = 4'b1000; set_len(3, 2); req_valid = 4'hF;
    req_data = {32'hD0D0_0003, 96'h0};
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) req = 4'h0;
      #1; checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL header c%0d: got %h expected %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    checks++;
    if (wr_log.size() != 4) begin
      errors++; $display("FAIL header_count: got %0d expected 4", wr_log.size());
    end else begin
      checks++;
      if (wr_log[0] !== hdr_exp) begin
        errors++; $display("FAIL header_word: got %h expected %h", wr_log[0], hdr_exp);
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (wr_log[k] !== 32'hD0D0_0003) begin
          errors++; $display("FAIL header_data[%0d]: got %h expected d0d00003", k, wr_log[k]);
        end
      end
    end
  endtask
`endif

  initial begin
    dut_wr = 0; bad_full = 0;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_clear();
    test_reset_mid_burst();
    test_random();
`ifdef AXI_FIFO_ARB_HDR_EN
    test_header();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
